// File: rtl/adc_sample_sequencer.sv
// SAR ADC pacing and averaging: issues timed start pulses, captures results on a
// synchronised end-of-conversion edge, averages 2^AVG_LOG2 of them and hands each average off on valid/ready.
module adc_sample_sequencer #(
  parameter int CLK_HZ         = 50_000_000,
  parameter int SAMPLE_HZ      = 20,
  parameter int AVG_LOG2       = 2,
  parameter int START_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 5_000_000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       enable,
  output logic       adc_start,
  input  logic       adc_eoc,
  input  logic [7:0] adc_value,
  output logic [7:0] sample_data,
  output logic       sample_valid,
  input  logic       sample_ready,
  output logic       timeout_err,
  output logic       overrun,
  input  logic       clear_err
);

  localparam int TICK_PERIOD = CLK_HZ / SAMPLE_HZ;
  localparam int TICK_W      = (TICK_PERIOD > 1) ? $clog2(TICK_PERIOD) : 1;
  localparam int START_W     = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
  localparam int TMO_W       = $clog2(TIMEOUT_CYCLES + 1);
  localparam int ACC_W       = 8 + AVG_LOG2;
  localparam int CNT_W       = AVG_LOG2 + 1;

  localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(TICK_PERIOD - 1);
  localparam logic [START_W-1:0] START_LAST = START_W'(START_CYCLES - 1);
  localparam logic [TMO_W-1:0]   TMO_LAST   = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]   AVG_N      = CNT_W'(2 ** AVG_LOG2);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT_EOC, S_ACCUM} state_t;

  state_t             state_q, state_d;
  logic [TICK_W-1:0]  tick_cnt_q, tick_cnt_d;
  logic [START_W-1:0] start_cnt_q, start_cnt_d;
  logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               eoc_sync1_q, eoc_sync1_d;
  logic               eoc_sync2_q, eoc_sync2_d;
  logic               eoc_prev_q, eoc_prev_d;
  logic               eoc_edge_q, eoc_edge_d;
  logic [7:0]         eoc_value_q, eoc_value_d;
  logic [7:0]         data_q, data_d;
  logic               valid_q, valid_d;
  logic               timeout_q, timeout_d;
  logic               overrun_q, overrun_d;

  logic tick;
  logic load;
  logic xfer;
  logic timeout_set;

  always_comb begin
    state_d     = state_q;
    start_cnt_d = start_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    acc_d       = acc_q;
    count_d     = count_q;
    load        = 1'b0;
    timeout_set = 1'b0;

    tick       = (tick_cnt_q == TICK_LAST);
    tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);

    // Edge is flagged one cycle after the second sync stage sees it; the value is
    // sampled on that same edge, well after adc_value has settled.
    eoc_sync1_d = adc_eoc;
    eoc_sync2_d = eoc_sync1_q;
    eoc_prev_d  = eoc_sync2_q;
    eoc_edge_d  = eoc_sync2_q & ~eoc_prev_q;
    eoc_value_d = eoc_edge_d ? adc_value : eoc_value_q;

    case (state_q)
      S_IDLE: begin
        if (!enable) begin
          acc_d   = '0;
          count_d = '0;
        end else if (tick) begin
          state_d     = S_START;
          start_cnt_d = '0;
        end
      end
      S_START: begin
        start_cnt_d = start_cnt_q + START_W'(1);
        if (start_cnt_q == START_LAST) begin
          state_d   = S_WAIT_EOC;
          tmo_cnt_d = '0;
        end
      end
      S_WAIT_EOC: begin
        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        // A result arriving on the final timeout cycle still counts.
        if (eoc_edge_q) begin
          acc_d   = acc_q + ACC_W'(eoc_value_q);
          count_d = count_q + CNT_W'(1);
          state_d = S_ACCUM;
        end else if (tmo_cnt_q == TMO_LAST) begin
          timeout_set = 1'b1;
          acc_d       = '0;
          count_d     = '0;
          state_d     = S_IDLE;
        end
      end
      S_ACCUM: begin
        state_d = S_IDLE;
        if (count_q == AVG_N) begin
          load    = 1'b1;
          acc_d   = '0;
          count_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    xfer      = valid_q & sample_ready;
    data_d    = load ? acc_q[ACC_W-1:AVG_LOG2] : data_q;
    valid_d   = load | (valid_q & ~xfer);
    overrun_d = (overrun_q & ~clear_err) | (load & valid_q & ~xfer);
    timeout_d = (timeout_q & ~clear_err) | timeout_set;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      tick_cnt_q  <= '0;
      start_cnt_q <= '0;
      tmo_cnt_q   <= '0;
      acc_q       <= '0;
      count_q     <= '0;
      eoc_sync1_q <= 1'b0;
      eoc_sync2_q <= 1'b0;
      eoc_prev_q  <= 1'b0;
      eoc_edge_q  <= 1'b0;
      eoc_value_q <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      timeout_q   <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      start_cnt_q <= start_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      eoc_sync1_q <= eoc_sync1_d;
      eoc_sync2_q <= eoc_sync2_d;
      eoc_prev_q  <= eoc_prev_d;
      eoc_edge_q  <= eoc_edge_d;
      eoc_value_q <= eoc_value_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      timeout_q   <= timeout_d;
      overrun_q   <= overrun_d;
    end
  end

  assign adc_start    = (state_q == S_START);
  assign sample_data  = data_q;
  assign sample_valid = valid_q;
  assign timeout_err  = timeout_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_adc_sample_sequencer.sv
// Directed bench for adc_sample_sequencer with a simple SAR converter model
// (eoc rises 5 cycles after adc_start falls and stays high for 3 cycles).
module tb_adc_sample_sequencer;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0;
  logic       adc_start;
  logic       adc_eoc;
  logic [7:0] adc_value;
  logic [7:0] sample_data;
  logic       sample_valid;
  logic       sample_ready = 1'b0;
  logic       timeout_err;
  logic       overrun;
  logic       clear_err = 1'b0;

  int checks = 0;
  int failures = 0;

  logic [7:0] sar_vals [0:15];
  logic [3:0] sar_idx = '0;
  bit         sar_on = 1'b1;

  always #5 clock = ~clock;

  adc_sample_sequencer #(
    .CLK_HZ(1000), .SAMPLE_HZ(100), .AVG_LOG2(2), .START_CYCLES(2), .TIMEOUT_CYCLES(50)
  ) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .adc_start(adc_start),
    .adc_eoc(adc_eoc), .adc_value(adc_value), .sample_data(sample_data),
    .sample_valid(sample_valid), .sample_ready(sample_ready), .timeout_err(timeout_err),
    .overrun(overrun), .clear_err(clear_err)
  );

  // SAR converter model, driven 1 ns after the rising edge.
  initial begin
    logic start_prev;
    start_prev = 1'b0;
    adc_eoc = 1'b0;
    adc_value = '0;
    forever begin
      @(posedge clock); #1;
      if (start_prev && !adc_start && sar_on) begin
        repeat (5) @(posedge clock);
        #1;
        adc_value = sar_vals[sar_idx];
        sar_idx = sar_idx + 4'd1;
        adc_eoc = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        adc_eoc = 1'b0;
      end
      start_prev = adc_start;
    end
  end

  // Waits on negedges until the chosen signal reaches level: 0 valid, 1 start, 2 eoc, 3 overrun.
  task automatic wait_for(input int which, input logic level, input int bound, output bit ok);
    logic s;
    ok = 1'b0;
    for (int n = 0; n < bound; n++) begin
      @(negedge clock);
      case (which)
        0: s = sample_valid;
        1: s = adc_start;
        2: s = adc_eoc;
        default: s = overrun;
      endcase
      if (s === level) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic quiesce();
    enable = 1'b0;
    sample_ready = 1'b1;
    clear_err = 1'b0;
    repeat (40) @(negedge clock);
  endtask

  task automatic load_vals(input logic [7:0] a, b, c, d, e, f, g, h);
    sar_vals[0] = a; sar_vals[1] = b; sar_vals[2] = c; sar_vals[3] = d;
    sar_vals[4] = e; sar_vals[5] = f; sar_vals[6] = g; sar_vals[7] = h;
    for (int i = 8; i < 16; i++) sar_vals[i] = 8'd0;
    sar_idx = '0;
  endtask

  task automatic test_reset();
    bit seen_start;
    repeat (3) @(negedge clock);
    checks++;
    if ({adc_start, sample_valid, sample_data, timeout_err, overrun} !== 12'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=000", {adc_start, sample_valid, sample_data, timeout_err, overrun});
    end
    reset_n = 1'b1;
    seen_start = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clock);
      if (adc_start) seen_start = 1'b1;
    end
    checks++;
    if (seen_start !== 1'b0) begin
      failures++;
      $display("FAIL idle_no_start got=%0b exp=0", seen_start);
    end
    checks++;
    if ({sample_valid, sample_data, timeout_err, overrun} !== 11'd0) begin
      failures++;
      $display("FAIL idle_outputs got=%h exp=000", {sample_valid, sample_data, timeout_err, overrun});
    end
  endtask

  task automatic test_average();
    bit ok;
    load_vals(8'd10, 8'd20, 8'd30, 8'd41, 8'd0, 8'd0, 8'd0, 8'd0);
    sample_ready = 1'b1;
    enable = 1'b1;
    wait_for(0, 1'b1, 150, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL avg_valid_wait got=timeout exp=valid"); end
    checks++;
    if (sample_data !== 8'd25) begin
      failures++;
      $display("FAIL avg_data got=%0d exp=25", sample_data);
    end
    @(negedge clock);
    checks++;
    if (sample_valid !== 1'b0) begin
      failures++;
      $display("FAIL avg_valid_pulse got=%0b exp=0", sample_valid);
    end
    quiesce();
  endtask

  task automatic test_overrun();
    bit ok;
    load_vals(8'd40, 8'd40, 8'd40, 8'd40, 8'd80, 8'd80, 8'd80, 8'd80);
    sample_ready = 1'b0;
    enable = 1'b1;
    wait_for(0, 1'b1, 150, ok);
    checks++;
    if (!ok || sample_data !== 8'd40 || overrun !== 1'b0) begin
      failures++;
      $display("FAIL ovr_first got=ok%0b data=%0d ovr=%0b exp=ok1 data=40 ovr=0", ok, sample_data, overrun);
    end
    wait_for(3, 1'b1, 150, ok);
    enable = 1'b0;
    checks++;
    if (!ok || sample_data !== 8'd80 || sample_valid !== 1'b1) begin
      failures++;
      $display("FAIL ovr_second got=ok%0b data=%0d valid=%0b exp=ok1 data=80 valid=1", ok, sample_data, sample_valid);
    end
    clear_err = 1'b1;
    @(negedge clock);
    clear_err = 1'b0;
    checks++;
    if (overrun !== 1'b0 || sample_valid !== 1'b1 || sample_data !== 8'd80) begin
      failures++;
      $display("FAIL ovr_clear got=ovr%0b valid=%0b data=%0d exp=ovr0 valid1 data=80", overrun, sample_valid, sample_data);
    end
    sample_ready = 1'b1;
    @(negedge clock);
    checks++;
    if (sample_valid !== 1'b0) begin
      failures++;
      $display("FAIL ovr_drain got=%0b exp=0", sample_valid);
    end
    quiesce();
  endtask

  task automatic test_timeout();
    bit ok;
    sar_on = 1'b0;
    sample_ready = 1'b0;
    enable = 1'b1;
    wait_for(1, 1'b1, 30, ok);
    wait_for(1, 1'b0, 10, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL tmo_start_wait got=timeout exp=start_pulse"); end
    repeat (49) @(negedge clock);
    checks++;
    if (timeout_err !== 1'b0) begin
      failures++;
      $display("FAIL tmo_early got=%0b exp=0", timeout_err);
    end
    @(negedge clock);
    checks++;
    if (timeout_err !== 1'b1 || sample_valid !== 1'b0) begin
      failures++;
      $display("FAIL tmo_at_50 got=err%0b valid%0b exp=err1 valid0", timeout_err, sample_valid);
    end
    wait_for(1, 1'b1, 12, ok);
    enable = 1'b0;
    checks++;
    if (!ok) begin failures++; $display("FAIL tmo_restart got=no_start exp=start"); end
    repeat (60) @(negedge clock);
    checks++;
    if (timeout_err !== 1'b1) begin
      failures++;
      $display("FAIL tmo_sticky got=%0b exp=1", timeout_err);
    end
    clear_err = 1'b1;
    @(negedge clock);
    clear_err = 1'b0;
    checks++;
    if (timeout_err !== 1'b0) begin
      failures++;
      $display("FAIL tmo_clear got=%0b exp=0", timeout_err);
    end
    sar_on = 1'b1;
    quiesce();
  endtask

  task automatic test_reset_midway();
    bit ok;
    load_vals(8'd200, 8'd200, 8'd200, 8'd100, 8'd100, 8'd100, 8'd100, 8'd0);
    sample_ready = 1'b1;
    enable = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_for(1, 1'b1, 30, ok);
      wait_for(1, 1'b0, 10, ok);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({adc_start, sample_valid, sample_data, timeout_err, overrun} !== 12'd0) begin
      failures++;
      $display("FAIL rst_mid_outputs got=%h exp=000", {adc_start, sample_valid, sample_data, timeout_err, overrun});
    end
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    wait_for(0, 1'b1, 150, ok);
    checks++;
    if (!ok || sample_data !== 8'd100) begin
      failures++;
      $display("FAIL rst_mid_data got=ok%0b data=%0d exp=ok1 data=100", ok, sample_data);
    end
    quiesce();
  endtask

  task automatic test_back_to_back();
    bit ok;
    load_vals(8'd8, 8'd8, 8'd8, 8'd8, 8'd60, 8'd61, 8'd62, 8'd63);
    sample_ready = 1'b0;
    enable = 1'b1;
    wait_for(0, 1'b1, 150, ok);
    checks++;
    if (!ok || sample_data !== 8'd8) begin
      failures++;
      $display("FAIL b2b_first got=ok%0b data=%0d exp=ok1 data=8", ok, sample_data);
    end
    for (int k = 0; k < 4; k++) begin
      wait_for(2, 1'b0, 40, ok);
      wait_for(2, 1'b1, 40, ok);
    end
    repeat (4) @(negedge clock);
    checks++;
    if (sample_valid !== 1'b1 || sample_data !== 8'd8) begin
      failures++;
      $display("FAIL b2b_hold got=valid%0b data=%0d exp=valid1 data=8", sample_valid, sample_data);
    end
    sample_ready = 1'b1;
    @(negedge clock);
    checks++;
    if (sample_valid !== 1'b1 || sample_data !== 8'd61 || overrun !== 1'b0) begin
      failures++;
      $display("FAIL b2b_load_xfer got=valid%0b data=%0d ovr=%0b exp=valid1 data=61 ovr0", sample_valid, sample_data, overrun);
    end
    @(negedge clock);
    checks++;
    if (sample_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_drain got=%0b exp=0", sample_valid);
    end
    quiesce();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) sar_vals[i] = 8'd0;
    test_reset();
    test_average();
    test_overrun();
    test_timeout();
    test_reset_midway();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
